// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE
  } ps2_state_t;

  // Keyboard command and response bytes
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_RESEND  = 8'hFE;

  // Bit positions inside the set-LED mask byte
  localparam int LED_SCROLL = 0;
  localparam int LED_NUM    = 1;
  localparam int LED_CAPS   = 2;

  // PS/2 frames carry odd parity over the eight data bits
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer, run-length glitch filter and falling-edge strobe
// for one open-drain PS/2 line. Lines idle high, so everything resets to 1.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] run_cnt;

  // Synchronize, then accept a new level only after FILTER_LEN agreeing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      level   <= 1'b1;
      fall    <= 1'b0;
      run_cnt <= '0;
    end else begin
      sync_p0 <= line_in;
      sync_p1 <= sync_p0;
      fall    <= 1'b0;
      if (sync_p1 == level) begin
        run_cnt <= '0;
      end else if (run_cnt == CNT_LAST) begin
        level   <= sync_p1;
        fall    <= ~sync_p1;
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift out
// data/parity/stop on device clock falling edges, then sample the device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 50000000,
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned START_TIMEOUT  = 750000,
  parameter int unsigned PKT_TIMEOUT    = 100000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       ack_ok,
  output logic       err_timeout,
  output logic       err_noack
);

  // The device needs the clock held low for at least 100 us; never go below that.
  localparam int unsigned MIN_INHIBIT = CLK_FREQ_HZ / 10000;
  localparam int unsigned INHIBIT_LEN = (INHIBIT_CYCLES > MIN_INHIBIT) ? INHIBIT_CYCLES : MIN_INHIBIT;
  localparam int unsigned TMAX        = (START_TIMEOUT > PKT_TIMEOUT) ? START_TIMEOUT : PKT_TIMEOUT;
  localparam int IW = $clog2(INHIBIT_LEN + 1);
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [IW-1:0] INHIBIT_LAST = IW'(INHIBIT_LEN - 1);
  localparam logic [TW-1:0] START_LAST   = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] PKT_LAST     = TW'(PKT_TIMEOUT - 1);

  ps2_state_t    state;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] timer;
  logic [9:0]    frame;
  logic [3:0]    idx;
  logic          abort;
  logic          timed_out;
  logic          clk_level;
  logic          clk_fall;
  logic          data_level;
  logic          data_fall_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk    (clk),
    .reset  (reset),
    .line_in(ps2_clk_in),
    .level  (clk_level),
    .fall   (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk    (clk),
    .reset  (reset),
    .line_in(ps2_data_in),
    .level  (data_level),
    .fall   (data_fall_unused)
  );

  // Start window runs until the first device edge, packet window until the ACK sample
  always_comb begin
    timed_out = 1'b0;
    if (state == SHIFT && idx == 4'd0) begin
      timed_out = (timer >= START_LAST);
    end else if (state == SHIFT || state == ACK) begin
      timed_out = (timer >= PKT_LAST);
    end
  end

  // Transaction FSM; all bus enables and result flags are registered here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      inh_cnt     <= '0;
      timer       <= '0;
      frame       <= '0;
      idx         <= '0;
      abort       <= 1'b0;
      tx_ready    <= 1'b0;
      busy        <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      ack_ok      <= 1'b0;
      err_timeout <= 1'b0;
      err_noack   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (done) begin
        ack_ok      <= 1'b0;
        err_timeout <= 1'b0;
        err_noack   <= 1'b0;
      end
      if (state != IDLE && timer != '1) begin
        timer <= timer + 1'b1;
      end

      if (abort) begin
        // Lines were already released when the timeout hit; report and finish
        abort    <= 1'b0;
        done     <= 1'b1;
        busy     <= 1'b0;
        tx_ready <= 1'b1;
        state    <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            tx_ready <= 1'b1;
            if (tx_valid && tx_ready) begin
              frame      <= {1'b1, odd_parity(tx_data), tx_data};
              inh_cnt    <= '0;
              ps2_clk_oe <= 1'b1;
              busy       <= 1'b1;
              tx_ready   <= 1'b0;
              state      <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (inh_cnt == INHIBIT_LAST) begin
              ps2_data_oe <= 1'b1;
              state       <= REQ;
            end else begin
              inh_cnt <= inh_cnt + 1'b1;
            end
          end
          REQ: begin
            ps2_clk_oe <= 1'b0;
            timer      <= '0;
            idx        <= '0;
            state      <= SHIFT;
          end
          SHIFT: begin
            if (timed_out) begin
              ps2_clk_oe  <= 1'b0;
              ps2_data_oe <= 1'b0;
              err_timeout <= 1'b1;
              abort       <= 1'b1;
            end else if (clk_fall) begin
              ps2_data_oe <= ~frame[idx];
              idx         <= idx + 1'b1;
              if (idx == 4'd0) begin
                timer <= '0;
              end
              if (idx == 4'd9) begin
                state <= ACK;
              end
            end
          end
          ACK: begin
            if (timed_out) begin
              ps2_clk_oe  <= 1'b0;
              ps2_data_oe <= 1'b0;
              err_timeout <= 1'b1;
              abort       <= 1'b1;
            end else if (clk_fall) begin
              ack_ok    <= ~data_level;
              err_noack <= data_level;
              state     <= WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            if (clk_level && data_level) begin
              done     <= 1'b1;
              busy     <= 1'b0;
              tx_ready <= 1'b1;
              state    <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs followed by a Caps/Num/Scroll mask, or 0xFF reset.
- Pairs with the existing PS2Receiver on the same PS2_CLK/PS2_DATA pins through open-drain enables at the top level.
- Runs on the 50 MHz divided clock. Owns the bus-inhibit, request-to-send, bit-shift and device-ACK phases.
- Flags the receiver to ignore the bus while a transmit is active.

Parameters:
- CLK_FREQ_HZ, 50000000, frequency of clk. Used only for documentation and constant derivation.
- INHIBIT_CYCLES, 6000, clk cycles PS2 clock is held low before the request (120 µs at 50 MHz; minimum 100 µs).
- START_TIMEOUT, 750000, maximum clk cycles from clock release to the first device falling edge (15 ms).
- PKT_TIMEOUT, 100000, maximum clk cycles from the first falling edge to the ACK sample (2 ms).
- FILTER_LEN, 8, consecutive equal synchronized samples required to accept a new level on a PS/2 line.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- tx_valid  in  1  request to send tx_data; accepted when tx_ready=1
- tx_data  in  8  command byte
- tx_ready  out  1  1 only in IDLE
- busy  out  1  1 in every state except IDLE; top level gates PS2Receiver ready with it
- ps2_clk_in  in  1  raw PS2_CLK pin level
- ps2_data_in  in  1  raw PS2_DATA pin level
- ps2_clk_oe  out  1  1 = drive PS2_CLK low, 0 = release (pull-up)
- ps2_data_oe  out  1  1 = drive PS2_DATA low, 0 = release
- done  out  1  one-cycle pulse at end of every transaction, success or failure
- ack_ok  out  1  valid with done: device ACKed
- err_timeout  out  1  valid with done: start or packet timeout
- err_noack  out  1  valid with done: ACK bit sampled high

Behaviour:
- Reset (async) values:
  - ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, ack_ok=0, err_timeout=0, err_noack=0.
  - tx_ready=1 from the first clk edge after reset deasserts.
  - State=IDLE; all counters 0.
  - Reset mid-transaction releases both lines immediately, with no done pulse.
- Line inputs: 2-flop synchronizer, then FILTER_LEN-sample glitch filter, then falling-edge strobe (1 cycle) on the filtered clock.
- Handshake: tx_valid && tx_ready latches tx_data and odd parity (~^tx_data) into a shift register; the next cycle is INHIBIT. tx_valid is ignored while busy.
- INHIBIT: ps2_clk_oe=1, ps2_data_oe=0. Lasts exactly INHIBIT_CYCLES cycles, then REQ.
- REQ: ps2_data_oe=1 (start bit 0) for 1 cycle with the clock still low. Then ps2_clk_oe=0, start timer, go to SHIFT with bit index=0.
- SHIFT: on each filtered clock falling edge, set ps2_data_oe = ~frame[idx] and increment idx.
  - frame = {stop=1, parity, d7..d0}, d0 first.
  - Falling edges 1..8 present data, 9 presents parity, 10 presents stop (data released).
  - After edge 10, go to ACK.
- ACK: on falling edge 11, sample filtered data.
  - 0 → ack_ok. 1 → err_noack.
  - Either way go to WAIT_IDLE.
- WAIT_IDLE: wait until filtered clock and data are both 1. Then pulse done with the result flags for 1 cycle and return to IDLE.
  - Result flags are cleared on the cycle after done.
- Timeouts:
  - REQ→first falling edge exceeding START_TIMEOUT cycles → err_timeout.
  - First falling edge→ACK sample exceeding PKT_TIMEOUT cycles → err_timeout.
  - On timeout: release both lines the same cycle, pulse done next cycle, then IDLE. No WAIT_IDLE.
- Edge cases:
  - Falling edge and timeout in the same cycle: the timeout wins.
  - Glitches shorter than FILTER_LEN cycles are never counted as edges.
  - Counters saturate; no wrap.

Decomposition:
- Package ps2_pkg: state enum (IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE); command constants CMD_SET_LED=8'hED, CMD_RESET=8'hFF, RSP_ACK=8'hFA, RSP_RESEND=8'hFE; LED mask bit positions (Scroll=0, Num=1, Caps=2).
- Sub-module ps2_line_filter: synchronizer + glitch filter + falling-edge strobe, instantiated twice (clock and data).

Test Plan:
- Behavioural device model clocking at 12.5 kHz; send 0xED → bits 1,0,1,1,0,1,1,1 LSB-first, parity=1, stop=1 observed on device rising edges; model ACKs → done with ack_ok=1.
- Inhibit timing check → ps2_clk_oe high for exactly 6000 cycles; data_oe rises 1 cycle before clk_oe falls.
- Device never clocks → done with err_timeout=1 at 750000+1 cycles after REQ; both oe=0.
- Device leaves data high at the ACK clock, tx_data=0x02 (parity 0) → done with err_noack=1.
- 3-cycle glitch on PS2_CLK during SHIFT → no extra bit shifted; frame still correct.
- Assert reset at data bit 4 → both oe=0 within the same cycle, no done pulse; a new 0xFF send afterwards completes with ack_ok=1.
